// File: rtl/fpu_ret_pkg.sv
// Shared definitions for the FP retire collector: word width, port count,
// IEEE flag bit positions and the round-robin pointer increment.
package fpu_ret_pkg;

    localparam int RET_W = 14;
    localparam int NPORT = 6;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef logic [RET_W-1:0] ret_word_t;

    function automatic logic [2:0] port_inc(input logic [2:0] k);
        return (k == 3'(NPORT - 1)) ? 3'd0 : k + 3'd1;
    endfunction

endpackage

// File: rtl/fpu_ret_fifo.sv
// Per-port completion FIFO. A push into a full FIFO is still accepted when
// the same cycle pops it; free_nxt reports the free slots after this edge.
module fpu_ret_fifo
    import fpu_ret_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  ret_word_t     din,
    output ret_word_t     dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] free_nxt
);

    ret_word_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            push_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & (~full | pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop)
            cnt_nxt = cnt + CW'(1);
        else if (!push_ok && pop)
            cnt_nxt = cnt - CW'(1);
    end

    assign free_nxt = CW'(DEPTH) - cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt_nxt;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fpu_ret_collect.sv
// Retire-side collector: six non-stallable completion streams buffered per
// port, drained round-robin through one output register with sticky flags.
module fpu_ret_collect
    import fpu_ret_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RET_W-1:0]  u1_ret,
    input  logic [RET_W-1:0]  u2_ret,
    input  logic [RET_W-1:0]  u3_ret,
    input  logic [RET_W-1:0]  u4_ret,
    input  logic [RET_W-1:0]  u5_ret,
    input  logic [RET_W-1:0]  u6_ret,
    input  logic              u1_ret_en,
    input  logic              u2_ret_en,
    input  logic              u3_ret_en,
    input  logic              u4_ret_en,
    input  logic              u5_ret_en,
    input  logic              u6_ret_en,
    output logic [NPORT-1:0]  stall_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RET_W-1:0]  out_ret,
    output logic [2:0]        out_port,
    input  logic              flag_clr,
    output logic [4:0]        fpflags,
    output logic              ovf_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    ret_word_t         in_word   [NPORT];
    ret_word_t         fifo_dout [NPORT];
    logic [CW-1:0]     free_nxt  [NPORT];
    logic [NPORT-1:0]  in_en;
    logic [NPORT-1:0]  full;
    logic [NPORT-1:0]  empty;
    logic [NPORT-1:0]  pop;
    logic [NPORT-1:0]  ovf;

    logic [2:0]        rr;
    logic [2:0]        gnt_idx;
    logic              gnt_vld;
    logic              load;
    logic              fire;

    assign in_word = '{u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret};
    assign in_en   = {u6_ret_en, u5_ret_en, u4_ret_en, u3_ret_en, u2_ret_en, u1_ret_en};

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        fpu_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (in_en[i]),
            .pop      (pop[i]),
            .din      (in_word[i]),
            .dout     (fifo_dout[i]),
            .full     (full[i]),
            .empty    (empty[i]),
            .free_nxt (free_nxt[i])
        );
        assign pop[i] = load & gnt_vld & (gnt_idx == 3'(i));
        assign ovf[i] = in_en[i] & full[i] & ~pop[i];
    end

    // First non-empty port at or after rr, wrapping modulo NPORT.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int j = 0; j < NPORT; j++) begin
            int idx;
            idx = int'(rr) + j;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!gnt_vld && !empty[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = 3'(idx);
            end
        end
    end

    assign fire = out_valid & out_ready;
    assign load = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_ret   <= '0;
            out_port  <= '0;
            rr        <= '0;
        end else if (load) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_ret  <= fifo_dout[gnt_idx];
                out_port <= gnt_idx;
                rr       <= port_inc(gnt_idx);
            end
        end
    end

    // Sticky state: a same-cycle set always survives a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpflags <= '0;
            ovf_err <= 1'b0;
        end else begin
            fpflags <= (flag_clr ? 5'd0 : fpflags) | (fire ? out_ret[FLG_NV:FLG_NX] : 5'd0);
            ovf_err <= (flag_clr ? 1'b0 : ovf_err) | (|ovf);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_port <= '0;
        end else begin
            for (int i = 0; i < NPORT; i++)
                stall_port[i] <= (int'(free_nxt[i]) <= AFULL_LVL);
        end
    end

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Directed bench for fpu_ret_collect: latency, round-robin order, backpressure,
// full-with-pop, flag clear race and asynchronous reset.
module tb_fpu_ret_collect;

    logic        clk;
    logic        rst;
    logic [13:0] u_ret [6];
    logic [5:0]  u_en;
    logic [5:0]  stall_port;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_ret;
    logic [2:0]  out_port;
    logic        flag_clr;
    logic [4:0]  fpflags;
    logic        ovf_err;

    int total = 0;
    int fails = 0;

    fpu_ret_collect #(.DEPTH(4), .AFULL_LVL(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .u1_ret     (u_ret[0]),
        .u2_ret     (u_ret[1]),
        .u3_ret     (u_ret[2]),
        .u4_ret     (u_ret[3]),
        .u5_ret     (u_ret[4]),
        .u6_ret     (u_ret[5]),
        .u1_ret_en  (u_en[0]),
        .u2_ret_en  (u_en[1]),
        .u3_ret_en  (u_en[2]),
        .u4_ret_en  (u_en[3]),
        .u5_ret_en  (u_en[4]),
        .u6_ret_en  (u_en[5]),
        .stall_port (stall_port),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ret    (out_ret),
        .out_port   (out_port),
        .flag_clr   (flag_clr),
        .fpflags    (fpflags),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        u_en      = '0;
        flag_clr  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) u_ret[i] = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ret",   32'(out_ret),   0);
        chk("rst_port",  32'(out_port),  0);
        chk("rst_flags", 32'(fpflags),   0);
        chk("rst_ovf",   32'(ovf_err),   0);
        chk("rst_stall", 32'(stall_port), 0);

        // single write on port 3
        out_ready = 1'b1;
        u_ret[2] = 14'h0011; u_en[2] = 1'b1;
        tick();
        u_en = '0;
        chk("lat_no_bypass", 32'(out_valid), 0);
        tick();
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_ret",   32'(out_ret),   32'h0011);
        chk("lat_port",  32'(out_port),  2);
        tick();
        chk("lat_flags", 32'(fpflags),   32'b10001);
        chk("lat_drain", 32'(out_valid), 0);

        // round-robin: all six ports at once
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) u_ret[i] = 14'h0100 + 14'(i);
        u_en = 6'h3f;
        tick();
        u_en = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_valid", 32'(out_valid), 1);
            chk("rr_port",  32'(out_port),  32'(k));
            chk("rr_ret",   32'(out_ret),   32'h0100 + 32'(k));
        end
        tick();
        chk("rr_empty", 32'(out_valid), 0);
        chk("rr_flags", 32'(fpflags),   32'b00111);

        // backpressure on port 1: six writes, last one overflows
        do_reset();
        for (int n = 0; n < 6; n++) begin
            u_ret[0] = 14'h0200 + 14'(n); u_en[0] = 1'b1;
            tick();
            if (n == 1) begin
                chk("bp_stall_lo", 32'(stall_port), 0);
                chk("bp_hold_w0",  32'(out_ret),    32'h0200);
            end
            if (n == 3) chk("bp_stall_hi", 32'(stall_port), 32'b000001);
            if (n == 4) chk("bp_no_ovf",   32'(ovf_err),    0);
        end
        u_en = '0;
        chk("bp_ovf",   32'(ovf_err),   1);
        chk("bp_hold",  32'(out_ret),   32'h0200);
        chk("bp_hvld",  32'(out_valid), 1);
        out_ready = 1'b1;
        for (int n = 1; n < 5; n++) begin
            tick();
            chk("bp_drain", 32'(out_ret), 32'h0200 + 32'(n));
        end
        tick();
        chk("bp_dropped", 32'(out_valid), 0);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("bp_ovf_clr", 32'(ovf_err), 0);

        // full FIFO popped and written in the same cycle
        do_reset();
        for (int n = 0; n < 5; n++) begin
            u_ret[1] = 14'h0300 + 14'(n); u_en[1] = 1'b1;
            tick();
        end
        chk("fp_hold", 32'(out_ret), 32'h0300);
        out_ready = 1'b1;
        u_ret[1] = 14'h0305;
        tick();
        u_en = '0;
        chk("fp_no_ovf", 32'(ovf_err), 0);
        chk("fp_ret1",   32'(out_ret), 32'h0301);
        for (int n = 2; n < 6; n++) begin
            tick();
            chk("fp_drain", 32'(out_ret),  32'h0300 + 32'(n));
            chk("fp_port",  32'(out_port), 1);
        end
        tick();
        chk("fp_empty", 32'(out_valid), 0);

        // flag clear racing a set
        do_reset();
        out_ready = 1'b1;
        u_ret[0] = 14'h0010; u_ret[1] = 14'h0001;
        u_en[0] = 1'b1; u_en[1] = 1'b1;
        tick();
        u_en = '0;
        tick();
        chk("fr_first", 32'(out_ret), 32'h0010);
        tick();
        chk("fr_nv", 32'(fpflags), 32'b10000);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("fr_race", 32'(fpflags), 32'b00001);

        // asynchronous reset with words queued
        do_reset();
        for (int n = 0; n < 3; n++) begin
            u_ret[0] = 14'h0005 + 14'(n); u_en[0] = 1'b1;
            tick();
        end
        u_en = '0;
        chk("ar_pre", 32'(out_ret), 32'h0005);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_ret",   32'(out_ret),   0);
        chk("ar_port",  32'(out_port),  0);
        #1 rst = 1'b1;
        tick();
        out_ready = 1'b1;
        u_ret[5] = 14'h00aa; u_en[5] = 1'b1;
        tick();
        u_en = '0;
        tick();
        chk("ar_new_vld",  32'(out_valid), 1);
        chk("ar_new_port", 32'(out_port),  5);
        chk("ar_new_ret",  32'(out_ret),   32'h00aa);
        tick();
        chk("ar_discard", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
